// File: rtl/simple_bus_pkg.sv
// Shared types and width helpers for the simple_bus_rr interconnect.
// Index fields are sized for the largest supported host/device counts.
package simple_bus_pkg;

  localparam int MaxHostIdxW = 3;
  localparam int MaxDevIdxW  = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [MaxHostIdxW-1:0] host_idx;
    logic [MaxDevIdxW-1:0]  dev_idx;
    logic                   miss;
  } resp_track_t;

endpackage

// File: rtl/simple_bus_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant plus index, same cycle as request.
// Pointer moves past the winner after each grant and holds when nobody requests.
module simple_bus_rr_arb
  import simple_bus_pkg::*;
#(
  parameter  int NrHosts = 2,
  localparam int IdxW    = idx_w(NrHosts)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrHosts-1:0] req_i,
  output logic [NrHosts-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               vld_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  // Outer loop walks priority order from the pointer; inner loop finds which host that slot is.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < NrHosts; k++) begin
      for (int h = 0; h < NrHosts; h++) begin
        if (!vld_o && req_i[h] &&
            ((int'(ptr_q) + k == h) || (int'(ptr_q) + k == h + NrHosts))) begin
          vld_o    = 1'b1;
          gnt_o[h] = 1'b1;
          idx_o    = IdxW'(h);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (vld_o) begin
      ptr_d = (idx_o == IdxW'(NrHosts - 1)) ? '0 : idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/simple_bus_rr.sv
// Multi-host bus: same-cycle RR grant + base/mask decode, response routed back one cycle later.
// No backpressure beyond grant; misses get an error response. Optional SIMPLE_BUS_PERF_CNT_EN grant counters.
module simple_bus_rr
  import simple_bus_pkg::*;
#(
  parameter int NrHosts      = 2,
  parameter int NrDevices    = 3,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrHosts-1:0]                     host_req_i,
  output logic [NrHosts-1:0]                     host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]                     host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
  output logic [NrHosts-1:0]                     host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
  output logic [NrHosts-1:0]                     host_err_o,
  output logic [NrDevices-1:0]                   device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0] device_addr_o,
  output logic [NrDevices-1:0]                   device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]  device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]    device_wdata_o,
  input  logic [NrDevices-1:0]                   device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]    device_rdata_i,
  input  logic [NrDevices-1:0]                   device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask,
  output logic [NrHosts-1:0][31:0]               perf_grant_cnt_o
);

  localparam int HostIdxW = idx_w(NrHosts);
  localparam int DevIdxW  = idx_w(NrDevices);
  localparam int BeW      = DataWidth / 8;

  logic [NrHosts-1:0]      gnt;
  logic [HostIdxW-1:0]     gnt_idx;
  logic                    gnt_vld;
  logic [AddressWidth-1:0] sel_addr;
  logic                    sel_we;
  logic [BeW-1:0]          sel_be;
  logic [DataWidth-1:0]    sel_wdata;
  logic                    hit;
  logic [DevIdxW-1:0]      sel_dev;
  resp_track_t             track_q, track_d;
  logic                    r_vld, r_err;
  logic [DataWidth-1:0]    r_data;

  simple_bus_rr_arb #(.NrHosts(NrHosts)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (host_req_i),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign host_gnt_o = gnt;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (gnt[h]) begin
        sel_addr  = host_addr_i[h];
        sel_we    = host_we_i[h];
        sel_be    = host_be_i[h];
        sel_wdata = host_wdata_i[h];
      end
    end
  end

  // Descending scan so the lowest-index matching window is the last write and wins.
  always_comb begin
    hit     = 1'b0;
    sel_dev = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        hit     = 1'b1;
        sel_dev = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = gnt_vld && hit && (sel_dev == DevIdxW'(d));
      device_addr_o[d]  = device_req_o[d] ? sel_addr  : '0;
      device_we_o[d]    = device_req_o[d] ? sel_we    : 1'b0;
      device_be_o[d]    = device_req_o[d] ? sel_be    : '0;
      device_wdata_o[d] = device_req_o[d] ? sel_wdata : '0;
    end
  end

  always_comb begin
    track_d          = '0;
    track_d.valid    = gnt_vld;
    track_d.host_idx = MaxHostIdxW'(gnt_idx);
    track_d.dev_idx  = MaxDevIdxW'(sel_dev);
    track_d.miss     = !hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) track_q <= '0;
    else       track_q <= track_d;
  end

  always_comb begin
    r_vld  = 1'b0;
    r_err  = 1'b0;
    r_data = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (track_q.dev_idx == MaxDevIdxW'(d)) begin
        r_vld  = device_rvalid_i[d];
        r_err  = device_rvalid_i[d] & device_err_i[d];
        r_data = device_rvalid_i[d] ? device_rdata_i[d] : '0;
      end
    end
    if (track_q.miss) begin
      r_vld  = 1'b1;
      r_err  = 1'b1;
      r_data = '0;
    end
  end

  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = track_q.valid && (track_q.host_idx == MaxHostIdxW'(h)) && r_vld;
      host_rdata_o[h]  = host_rvalid_o[h] ? r_data : '0;
      host_err_o[h]    = host_rvalid_o[h] & r_err;
    end
  end

`ifdef SIMPLE_BUS_PERF_CNT_EN
  logic [NrHosts-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      cnt_d[h] = (gnt[h] && (cnt_q[h] != 32'hFFFF_FFFF)) ? cnt_q[h] + 32'd1 : cnt_q[h];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign perf_grant_cnt_o = cnt_q;
`else
  assign perf_grant_cnt_o = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int d = 0; d < NrDevices; d++) begin
        assert (!device_rvalid_i[d] ||
                (track_q.valid && !track_q.miss && track_q.dev_idx == MaxDevIdxW'(d)))
          else $error("stray device_rvalid_i on device %0d", d);
      end
    end
  end
`endif

endmodule

// File: tb/tb_simple_bus_rr.sv
// Directed bench for simple_bus_rr: behavioural devices, scoreboard of expected host responses.
module tb_simple_bus_rr;

  localparam int NH = 2;
  localparam int ND = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NH-1:0]          host_req_i = '0;
  logic [NH-1:0]          host_gnt_o;
  logic [NH-1:0][31:0]    host_addr_i = '0;
  logic [NH-1:0]          host_we_i = '0;
  logic [NH-1:0][3:0]     host_be_i = '0;
  logic [NH-1:0][31:0]    host_wdata_i = '0;
  logic [NH-1:0]          host_rvalid_o;
  logic [NH-1:0][31:0]    host_rdata_o;
  logic [NH-1:0]          host_err_o;
  logic [ND-1:0]          device_req_o;
  logic [ND-1:0][31:0]    device_addr_o;
  logic [ND-1:0]          device_we_o;
  logic [ND-1:0][3:0]     device_be_o;
  logic [ND-1:0][31:0]    device_wdata_o;
  logic [ND-1:0]          dev_rv;
  logic [ND-1:0][31:0]    dev_rd;
  logic [ND-1:0]          dev_er;
  logic [ND-1:0][31:0]    cfg_base = '0;
  logic [ND-1:0][31:0]    cfg_mask = '0;
  logic [NH-1:0][31:0]    perf_grant_cnt_o;

  always #5 clk = ~clk;

  simple_bus_rr #(.NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .host_req_i           (host_req_i),
    .host_gnt_o           (host_gnt_o),
    .host_addr_i          (host_addr_i),
    .host_we_i            (host_we_i),
    .host_be_i            (host_be_i),
    .host_wdata_i         (host_wdata_i),
    .host_rvalid_o        (host_rvalid_o),
    .host_rdata_o         (host_rdata_o),
    .host_err_o           (host_err_o),
    .device_req_o         (device_req_o),
    .device_addr_o        (device_addr_o),
    .device_we_o          (device_we_o),
    .device_be_o          (device_be_o),
    .device_wdata_o       (device_wdata_o),
    .device_rvalid_i      (dev_rv),
    .device_rdata_i       (dev_rd),
    .device_err_i         (dev_er),
    .cfg_device_addr_base (cfg_base),
    .cfg_device_addr_mask (cfg_mask),
    .perf_grant_cnt_o     (perf_grant_cnt_o)
  );

  // Devices answer one cycle after a request; device 2 flags writes as errors.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dev_rv <= '0;
      dev_rd <= '0;
      dev_er <= '0;
    end else begin
      for (int d = 0; d < ND; d++) begin
        dev_rv[d] <= device_req_o[d];
        dev_rd[d] <= device_req_o[d] ? (32'hD000_0000 | (32'(d) << 24) | (device_addr_o[d] & 32'h00FF_FFFF)) : 32'h0;
        dev_er[d] <= device_req_o[d] & device_we_o[d] & (d == 2);
      end
    end
  end

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt [NH];
  logic [31:0] h_addr  [NH];
  logic        h_we    [NH];

  function automatic logic [31:0] exp_rdata(input int d, input logic [31:0] a);
    return 32'hD000_0000 | (32'(d) << 24) | (a & 32'h00FF_FFFF);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic check_perf(input string tag);
    for (int h = 0; h < NH; h++) begin
`ifdef SIMPLE_BUS_PERF_CNT_EN
      check(tag, 64'(perf_grant_cnt_o[h]), 64'(exp_cnt[h]));
`else
      check(tag, 64'(perf_grant_cnt_o[h]), 64'd0);
`endif
    end
  endtask

  // One bus cycle: eg = expected granted host (-1 none), ed = expected device (-1 miss).
  task automatic cycle(input logic [NH-1:0] req, input int eg, input int ed);
    exp_t e;
    @(posedge clk);
    #1;
    host_req_i = req;
    for (int h = 0; h < NH; h++) begin
      host_addr_i[h]  = h_addr[h];
      host_we_i[h]    = h_we[h];
      host_be_i[h]    = 4'hF;
      host_wdata_i[h] = 32'hA5A5_0000 | 32'(h);
    end
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rvalid", 64'(host_rvalid_o), 64'(1) << e.host);
      check("rdata", 64'(host_rdata_o[e.host]), 64'(e.rdata));
      check("err", 64'(host_err_o[e.host]), 64'(e.err));
      check("rdata_other", 64'(host_rdata_o[1 - e.host]), 64'd0);
    end else begin
      check("rvalid_idle", 64'(host_rvalid_o), 64'd0);
    end
    check("gnt", 64'(host_gnt_o), (eg < 0) ? 64'd0 : (64'(1) << eg));
    check("dev_req", 64'(device_req_o), (eg < 0 || ed < 0) ? 64'd0 : (64'(1) << ed));
    if (eg >= 0) begin
      if (ed >= 0) begin
        check("dev_addr", 64'(device_addr_o[ed]), 64'(h_addr[eg]));
        check("dev_we", 64'(device_we_o[ed]), 64'(h_we[eg]));
      end
      e.host  = eg;
      e.rdata = (ed < 0) ? 32'h0 : exp_rdata(ed, h_addr[eg]);
      e.err   = (ed < 0) ? 1'b1 : (h_we[eg] && ed == 2);
      q.push_back(e);
      exp_cnt[eg]++;
    end
  endtask

  initial begin
    for (int h = 0; h < NH; h++) begin
      exp_cnt[h] = 0;
      h_addr[h]  = 32'h0;
      h_we[h]    = 1'b0;
    end
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", 64'(host_rvalid_o), 64'd0);
    check("rst_dev_req", 64'(device_req_o), 64'd0);
    check_perf("rst_perf");
    rst = 1'b0;
    cycle(2'b00, -1, -1);
    cycle(2'b00, -1, -1);
    check_perf("idle_perf");

    // Single read to RAM window
    h_addr[0] = 32'h0010_0004; h_we[0] = 1'b0;
    cycle(2'b01, 0, 0);
    cycle(2'b00, -1, -1);

    // Decode miss from host1 (pointer returns to 0 afterwards)
    h_addr[1] = 32'h0000_0000; h_we[1] = 1'b0;
    cycle(2'b10, 1, -1);
    cycle(2'b00, -1, -1);

    // Contention: host0 reads RAM, host1 writes device2
    h_addr[0] = 32'h0010_0010; h_we[0] = 1'b0;
    h_addr[1] = 32'h0003_0008; h_we[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(2'b11, 0, 0);
      cycle(2'b11, 1, 2);
    end
    cycle(2'b00, -1, -1);

    // Overlapping windows: device1 must win over device2
    cfg_base[2] = 32'h0002_0000; cfg_mask[2] = ~32'h0000_03FF;
    h_addr[0] = 32'h0002_0010; h_we[0] = 1'b0;
    cycle(2'b01, 0, 1);
    h_addr[1] = 32'h0002_0004; h_we[1] = 1'b0;
    cycle(2'b10, 1, 1);
    cycle(2'b00, -1, -1);

    // Reset in the cycle after a grant: response discarded, pointer back to 0
    cycle(2'b01, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    host_req_i = '0;
    q.delete();
    for (int h = 0; h < NH; h++) exp_cnt[h] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_rvalid", 64'(host_rvalid_o), 64'd0);
    end
    check_perf("rst_mid_perf");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", 64'(host_rvalid_o), 64'd0);
    cycle(2'b11, 0, 1);
    cycle(2'b11, 1, 1);
    cycle(2'b00, -1, -1);
    cycle(2'b00, -1, -1);
    check_perf("final_perf");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
